// File: rtl/cla_pkg.sv
// cla_pkg: shared types, group lookahead function and parameter legality check for cla_pipe_adder
package cla_pkg;

    localparam int MAX_GROUP = 8;

    typedef struct packed {
        logic [MAX_GROUP:0] c;
        logic               gp;
        logic               gg;
    } la_t;

    function automatic bit params_ok(input int width, input int group);
        return group >= 1 && group <= MAX_GROUP && width >= group && width % group == 0;
    endfunction

    function automatic la_t lookahead(input logic [MAX_GROUP-1:0] p, input logic [MAX_GROUP-1:0] g,
                                      input logic c0, input int n);
        la_t  r;
        logic t;
        logic pr;
        r      = '0;
        r.c[0] = c0;
        for (int i = 1; i <= MAX_GROUP; i++) begin
            if (i <= n) begin
                t = c0;
                for (int j = 0; j < i; j++) t = t & p[j];
                for (int j = 0; j < i; j++) begin
                    pr = g[j];
                    for (int m = j + 1; m < i; m++) pr = pr & p[m];
                    t = t | pr;
                end
                r.c[i] = t;
            end
        end
        r.gp = 1'b1;
        r.gg = 1'b0;
        for (int j = 0; j < n; j++) begin
            r.gp = r.gp & p[j];
            pr   = g[j];
            for (int m = j + 1; m < n; m++) pr = pr & p[m];
            r.gg = r.gg | pr;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational G-bit lookahead slice; in a, b, c_in; out sum, c_out, c_msb_in (carry into slice MSB)
module cla_group
    import cla_pkg::*;
#(
    parameter int G = 4
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         c_in,
    output logic [G-1:0] sum,
    output logic         c_out,
    output logic         c_msb_in
);

    logic [G-1:0] p;
    logic [G-1:0] gn;
    la_t          r;
    logic         unused;

    assign p        = a ^ b;
    assign gn       = a & b;
    assign r        = lookahead(MAX_GROUP'(p), MAX_GROUP'(gn), c_in, G);
    assign sum      = p ^ r.c[G-1:0];
    assign c_out    = r.gg | (r.gp & c_in);
    assign c_msb_in = r.c[G-1];
    assign unused   = ^r;

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA add/sub, one group per stage; in clk rst_n in_valid a b cin sub out_ready; out in_ready out_valid sum cout ovf zero
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    if (!params_ok(WIDTH, GROUP)) begin : g_bad
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must be 1..8");
    end

    logic adv;
    logic ovf_r;
    logic zero_r;
    logic unused;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NG; k++) begin : g_st
        logic [WIDTH-1:0] ia, ib, ps, ns, ra, rb, rs;
        logic             ic, iv, rc, rv, gc, gm;
        logic [GROUP-1:0] gs;
        logic             unused_gm;
        if (k == 0) begin : g_head
            assign ia = a;
            assign ib = sub ? ~b : b;
            assign ps = '0;
            assign ic = sub ? ~cin : cin;
            assign iv = in_valid && in_ready;
        end else begin : g_link
            assign ia = g_st[k-1].ra;
            assign ib = g_st[k-1].rb;
            assign ps = g_st[k-1].rs;
            assign ic = g_st[k-1].rc;
            assign iv = g_st[k-1].rv;
        end
        cla_group #(.G(GROUP)) u_grp (
            .a        (ia[k*GROUP +: GROUP]),
            .b        (ib[k*GROUP +: GROUP]),
            .c_in     (ic),
            .sum      (gs),
            .c_out    (gc),
            .c_msb_in (gm)
        );
        assign unused_gm = gm;
        always_comb begin
            ns                     = ps;
            ns[k*GROUP +: GROUP]   = gs;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv <= 1'b0;
                ra <= '0;
                rb <= '0;
                rs <= '0;
                rc <= 1'b0;
            end else if (adv) begin
                rv <= iv;
                ra <= ia;
                rb <= ib;
                rs <= ns;
                rc <= gc;
            end
        end
    end

    // Last stage's group carries give the MSB carry-in/out pair for signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (adv) begin
            ovf_r  <= g_st[NG-1].gc ^ g_st[NG-1].gm;
            zero_r <= ~|g_st[NG-1].ns;
        end
    end

    assign out_valid = g_st[NG-1].rv;
    assign sum       = g_st[NG-1].rs;
    assign cout      = g_st[NG-1].rc;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign unused    = ^{g_st[NG-1].ra, g_st[NG-1].rb};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: randomized and directed checks of cla_pipe_adder at 16/4 and 8/1 against an arithmetic model
module tb_cla_pipe_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          chk_lat = 1'b1;
    exp_t        xq[$];
    exp_t        yq[$];

    logic        x_iv, x_ir, x_cin, x_sub, x_ov, x_or, x_cout, x_ovf, x_zero;
    logic [15:0] x_a, x_b, x_sum;
    logic        y_iv, y_ir, y_cin, y_sub, y_ov, y_or, y_cout, y_ovf, y_zero;
    logic [7:0]  y_a, y_b, y_sum;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut_x (
        .clk(clk), .rst_n(rst_n), .in_valid(x_iv), .in_ready(x_ir), .a(x_a), .b(x_b),
        .cin(x_cin), .sub(x_sub), .out_valid(x_ov), .out_ready(x_or), .sum(x_sum),
        .cout(x_cout), .ovf(x_ovf), .zero(x_zero)
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP(1)) dut_y (
        .clk(clk), .rst_n(rst_n), .in_valid(y_iv), .in_ready(y_ir), .a(y_a), .b(y_b),
        .cin(y_cin), .sub(y_sub), .out_valid(y_ov), .out_ready(y_or), .sum(y_sum),
        .cout(y_cout), .ovf(y_ovf), .zero(y_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input int t);
        exp_t        e;
        logic [16:0] mask, be, r;
        mask   = (17'd1 << w) - 17'd1;
        be     = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        r      = {1'b0, a} + be + 17'(sub ? !cin : cin);
        e.sum  = r[15:0] & mask[15:0];
        e.cout = r[w];
        e.ovf  = (a[w-1] == be[w-1]) && (r[w-1] != a[w-1]);
        e.zero = (e.sum == 16'd0);
        e.t    = t;
        return e;
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (x_ov) begin
            if (xq.size() == 0) check("x_extra", 32'(x_ov), 0);
            else begin
                check("x_sum", 32'(x_sum), 32'(xq[0].sum));
                check("x_cout", 32'(x_cout), 32'(xq[0].cout));
                check("x_ovf", 32'(x_ovf), 32'(xq[0].ovf));
                check("x_zero", 32'(x_zero), 32'(xq[0].zero));
                if (x_or) begin
                    if (chk_lat) check("x_lat", 32'(cyc - xq[0].t), 4);
                    void'(xq.pop_front());
                end
            end
        end
        if (x_iv && x_ir) xq.push_back(model(16, x_a, x_b, x_cin, x_sub, cyc));
    end

    always @(negedge clk) if (rst_n) begin
        if (y_ov) begin
            if (yq.size() == 0) check("y_extra", 32'(y_ov), 0);
            else begin
                check("y_sum", 32'(y_sum), 32'(yq[0].sum));
                check("y_cout", 32'(y_cout), 32'(yq[0].cout));
                check("y_ovf", 32'(y_ovf), 32'(yq[0].ovf));
                check("y_zero", 32'(y_zero), 32'(yq[0].zero));
                if (y_or) begin
                    if (chk_lat) check("y_lat", 32'(cyc - yq[0].t), 8);
                    void'(yq.pop_front());
                end
            end
        end
        if (y_iv && y_ir) yq.push_back(model(8, {8'h00, y_a}, {8'h00, y_b}, y_cin, y_sub, cyc));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_x();
        x_a   = 16'($urandom);
        x_b   = 16'($urandom);
        x_cin = 1'($urandom);
        x_sub = 1'($urandom);
    endtask

    task automatic dir_x(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        x_a = a; x_b = b; x_cin = cin; x_sub = sub; x_iv = 1'b1;
        tick();
        x_iv = 1'b0;
        repeat (2) tick();
        check("x_early", 32'(x_ov), 0);
        tick();
        check("x_valid", 32'(x_ov), 1);
        check("x_dsum", 32'(x_sum), 32'(es));
        check("x_dcout", 32'(x_cout), 32'(ec));
        check("x_dovf", 32'(x_ovf), 32'(eo));
        check("x_dzero", 32'(x_zero), 32'(ez));
        tick();
        check("x_gone", 32'(x_ov), 0);
    endtask

    task automatic drain();
        int i;
        x_iv = 1'b0; y_iv = 1'b0; x_or = 1'b1; y_or = 1'b1;
        for (i = 0; i < 100 && (xq.size() + yq.size()) != 0; i++) tick();
        check("drain", 32'(xq.size() + yq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        x_iv = 0; x_a = 0; x_b = 0; x_cin = 0; x_sub = 0; x_or = 1;
        y_iv = 0; y_a = 0; y_b = 0; y_cin = 0; y_sub = 0; y_or = 1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_x_ov", 32'(x_ov), 0);
        check("rst_x_ir", 32'(x_ir), 1);
        check("rst_x_out", 32'({x_sum, x_cout, x_ovf, x_zero}), 0);
        check("rst_y_ov", 32'(y_ov), 0);
        check("rst_y_out", 32'({y_sum, y_cout, y_ovf, y_zero}), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("rel_x_ir", 32'(x_ir), 1);
        tick();

        dir_x(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        dir_x(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
        dir_x(16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0, 0);
        dir_x(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        dir_x(16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            rand_x();
            x_iv = 1'b1;
            tick();
        end
        drain();

        chk_lat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_x();
            x_iv = 1'b1;
            tick();
        end
        check("stall_full", 32'(x_ov), 1);
        x_or = 1'b0;
        rand_x();
        #1;
        check("stall_ir", 32'(x_ir), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ir", 32'(x_ir), 0);
            check("stall_ov", 32'(x_ov), 1);
        end
        x_or = 1'b1;
        tick();
        drain();
        chk_lat = 1'b1;

        for (int i = 0; i < 3; i++) begin
            rand_x();
            x_iv = 1'b1;
            tick();
        end
        x_iv = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 32'(x_ov), 0);
        check("mid_rst_sum", 32'(x_sum), 0);
        xq.delete();
        yq.delete();
        tick();
        rst_n = 1'b1;
        check("mid_rel_ir", 32'(x_ir), 1);
        dir_x(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0, 0);

        y_a = 8'hFF; y_b = 8'h01; y_cin = 0; y_sub = 0; y_iv = 1'b1;
        tick();
        y_iv = 1'b0;
        repeat (6) tick();
        check("y_early", 32'(y_ov), 0);
        tick();
        check("y_valid", 32'(y_ov), 1);
        check("y_dsum", 32'(y_sum), 0);
        check("y_dcout", 32'(y_cout), 1);
        check("y_dovf", 32'(y_ovf), 0);
        check("y_dzero", 32'(y_zero), 1);
        tick();
        check("y_gone", 32'(y_ov), 0);

        chk_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_x();
            x_iv = ($urandom_range(0, 3) != 0);
            x_or = ($urandom_range(0, 3) != 0);
            y_a = 8'($urandom); y_b = 8'($urandom);
            y_cin = 1'($urandom); y_sub = 1'($urandom);
            y_iv = ($urandom_range(0, 3) != 0);
            y_or = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
